// File: rtl/nios_mult_pkg.sv
// Shared types and helpers for the iterative Nios II multiplier.
// Holds the FSM state encoding, the default operand geometry and the step-count helper.
// No logic of its own; imported by the multiplier top.
package nios_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;

    // Number of iterations needed to consume a width-bit multiplier chunk bits at a time.
    function automatic int steps(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/nios_mult_pp_cell.sv
// Unsigned WIDTH x CHUNK partial-product generator.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module nios_mult_pp_cell #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [CHUNK-1:0]       b,
    output logic [WIDTH+CHUNK-1:0] pp
);

    // Both operands zero-extended to the full product width so no bits are lost.
    assign pp = {{CHUNK{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/nios_mult_iter_cell.sv
// Iterative multiplier: consumes src_b CHUNK bits per cycle, shift-accumulates partial products.
// Latency: out_valid rises WIDTH/CHUNK edges after the accepting edge; DONE->RUN restarts with no bubble.
// Backpressure: result held in DONE until out_ready; in_ready low in RUN. Macro NIOS_MULT_HIGH_EN adds signed 64-bit product.
module nios_mult_iter_cell
    import nios_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy
);

    localparam int STEPS  = steps(WIDTH, CHUNK);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
`ifdef NIOS_MULT_HIGH_EN
    localparam int ACC_W  = 2 * WIDTH;
`else
    localparam int ACC_W  = WIDTH;
`endif

    // A chunk that does not tile the operand would leave multiplier bits unprocessed.
    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("nios_mult_iter_cell: CHUNK must divide WIDTH");
        end
    endgenerate

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ACC_W-1:0]   acc;
    logic [STEP_W-1:0]  step;
    logic [WIDTH-1:0]   res_lo_q;

    logic [CHUNK-1:0]       chunk_b;
    logic [WIDTH+CHUNK-1:0] pp;
    logic [ACC_W-1:0]       pp_sh;
    logic [ACC_W-1:0]       acc_sum;
    logic [ACC_W-1:0]       prod_final;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   last_step;
    logic                   accept;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last_step = (step == STEP_W'(STEPS - 1));
    assign result_lo = res_lo_q;

    // Current multiplier chunk, selected by the step counter.
    assign chunk_b = b_q[int'(step) * CHUNK +: CHUNK];

    nios_mult_pp_cell #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_pp (
        .a  (a_q),
        .b  (chunk_b),
        .pp (pp)
    );

    // Align the partial product to its chunk position; bits beyond the accumulator drop off.
    assign pp_sh   = ACC_W'(pp) << (int'(step) * CHUNK);
    assign acc_sum = acc + pp_sh;

`ifdef NIOS_MULT_HIGH_EN
    logic             neg_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             neg_in;

    // Signed operands are multiplied as magnitudes; the sign is reapplied on the final load.
    assign neg_in     = (sign_a & src_a[WIDTH-1]) ^ (sign_b & src_b[WIDTH-1]);
    assign a_mag      = (sign_a & src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag      = (sign_b & src_b[WIDTH-1]) ? -src_b : src_b;
    assign prod_final = neg_q ? -acc_sum : acc_sum;
    assign result_hi  = res_hi_q;

    // Sign flag and upper result word, loaded alongside the operands and the low word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_q    <= 1'b0;
            res_hi_q <= '0;
        end else if (!flush) begin
            if (accept && (state != RUN)) begin
                neg_q <= neg_in;
            end
            if ((state == RUN) && last_step) begin
                res_hi_q <= prod_final[ACC_W-1:WIDTH];
            end
        end
    end
`else
    logic unused_sign;

    // Low-word-only build: operands are always unsigned, the high word does not exist.
    assign unused_sign = sign_a ^ sign_b;
    assign a_mag       = src_a;
    assign b_mag       = src_b;
    assign prod_final  = acc_sum;
    assign result_hi   = '0;
`endif

    // Main FSM: operand capture, per-step accumulate, result load and output handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            step      <= '0;
            res_lo_q  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            // Abort wins over every handshake; the last presented result stays readable.
            state     <= IDLE;
            acc       <= '0;
            step      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a_mag;
                        b_q   <= b_mag;
                        acc   <= '0;
                        step  <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    if (last_step) begin
                        step      <= '0;
                        res_lo_q  <= prod_final[WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            acc   <= '0;
                            step  <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_mult_iter_cell.sv
// Self-checking bench for nios_mult_iter_cell: vector table plus handshake corner sequences.
// Expected results are queued when an operand handshake is driven and compared when the result is taken.
// Builds with or without NIOS_MULT_HIGH_EN; high-word expectations follow the build.
module tb_nios_mult_iter_cell;

`ifdef NIOS_MULT_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif
    localparam int STEPS = 8;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        sign_a;
    logic        sign_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [31:0] lo;
        logic [31:0] hi;   // upper product word when the high-word build is used
    } vec_t;

    exp_t scb[$];
    vec_t vecs[11];

    nios_mult_iter_cell #(
        .WIDTH (32),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Result monitor: a transfer happens on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !flush) begin
            if (scb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_result: got lo=%h hi=%h, want no result", result_lo, result_hi);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check("result_lo", {32'h0, result_lo}, {32'h0, e.lo});
                check("result_hi", {32'h0, result_hi}, {32'h0, e.hi});
            end
        end
    end

    // Present one operand pair, wait (bounded) for acceptance, queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                         input logic [31:0] lo, input logic [31:0] hi, input bit push);
        int n;
        src_a    = a;
        src_b    = b;
        sign_a   = sa;
        sign_b   = sb;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {63'h0, in_ready}, 64'h1);
        if (push) scb.push_back('{lo: lo, hi: (HIGH_EN ? hi : 32'h0)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until every queued result has been consumed.
    task automatic drain();
        int n;
        n = 0;
        while ((scb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", {63'h0, (n < 100)}, 64'h1);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_rises", {63'h0, out_valid}, 64'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] saved;
        int          lat;
        bit          rdy_in_run;
        int          n;

        vecs[0]  = '{32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_002A, 32'h0000_0000};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001};
        vecs[6]  = '{32'h1234_5678, 32'h0000_0010, 1'b0, 1'b0, 32'h2345_6780, 32'h0000_0001};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8]  = '{32'h0000_0003, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFE};
        vecs[9]  = '{32'h0000_0064, 32'h7FFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'h0000_0031};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        src_a     = '0;
        src_b     = '0;
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_result_lo", {32'h0, result_lo}, 64'h0);
        check("rst_result_hi", {32'h0, result_hi}, 64'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // Single op: latency from the accepting edge, in_ready low during RUN.
        issue(32'h7, 32'h6, 1'b0, 1'b0, 32'h2A, 32'h0, 1'b1);
        lat = 0;
        rdy_in_run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready) rdy_in_run = 1'b1;
        end
        check("latency", lat, STEPS);
        check("in_ready_in_run", {63'h0, rdy_in_run}, 64'h0);
        drain();

        // Vector table, one isolated op each.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].lo, vecs[i].hi, 1'b1);
            drain();
        end

        // Back-to-back with in_valid held: next accept coincides with the previous result transfer.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            src_a  = vecs[k * 4 + 1].a;
            src_b  = vecs[k * 4 + 1].b;
            sign_a = vecs[k * 4 + 1].sa;
            sign_b = vecs[k * 4 + 1].sb;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("b2b_accept_ready", {63'h0, in_ready}, 64'h1);
            if (k > 0) begin
                check("b2b_with_result", {63'h0, out_valid}, 64'h1);
                check("b2b_gap", n, STEPS);
            end
            scb.push_back('{lo: vecs[k * 4 + 1].lo, hi: (HIGH_EN ? vecs[k * 4 + 1].hi : 32'h0)});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: result held stable for five cycles, taken on the first ready edge.
        out_ready = 1'b0;
        issue(vecs[6].a, vecs[6].b, 1'b0, 1'b0, vecs[6].lo, vecs[6].hi, 1'b1);
        wait_out_valid();
        saved = result_lo;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {63'h0, out_valid}, 64'h1);
            check("bp_result_lo", {32'h0, result_lo}, {32'h0, saved});
            check("bp_in_ready", {63'h0, in_ready}, 64'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_taken", {63'h0, out_valid}, 64'h0);
        check("bp_queue_empty", scb.size(), 0);

        // Flush in DONE beats a simultaneous take-and-accept; last result stays readable.
        out_ready = 1'b0;
        issue(32'h7, 32'h6, 1'b0, 1'b0, 32'h2A, 32'h0, 1'b0);
        wait_out_valid();
        @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        src_a     = 32'h10;
        src_b     = 32'h10;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_done_out_valid", {63'h0, out_valid}, 64'h0);
        check("flush_done_busy", {63'h0, busy}, 64'h0);
        check("flush_keeps_result", {32'h0, result_lo}, 64'h2A);

        // Flush on the edge that would process step 3.
        issue(32'h5, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_run_busy", {63'h0, busy}, 64'h0);
        check("flush_run_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (12) @(posedge clk);
        #1;
        check("flush_run_no_result", {63'h0, out_valid}, 64'h0);

        // Reset pulse around step 5.
        issue(32'h9, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        check("rst_run_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_run_busy", {63'h0, busy}, 64'h0);
        check("rst_run_result_lo", {32'h0, result_lo}, 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_run_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (12) @(posedge clk);
        #1;
        check("rst_run_no_result", {63'h0, out_valid}, 64'h0);

        // Recovery op after abort.
        issue(32'h10, 32'h10, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
